// File: rtl/wb_stage.sv
// Write-back stage: decodes the retiring instruction, forms the register write
// (sub-word load extraction, link address), owns the GRF and a retire counter.
module wb_stage #(
    parameter logic [31:0] LINK_OFFSET = 32'd8,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      W_Instr,
    input  logic [31:0]      W_pc,
    input  logic [31:0]      W_C,
    input  logic [31:0]      W_RD,
    input  logic [31:0]      W_EXTout,
    input  logic [4:0]       A1,
    input  logic [4:0]       A2,
    output logic [31:0]      RD1,
    output logic [31:0]      RD2,
    output logic             W_WE,
    output logic [4:0]       W_A3,
    output logic [31:0]      W_WD,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] link_addr;
    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        dec_write;
    logic [4:0]  dec_a3;
    logic [31:0] dec_wd;
    logic        unused_bits;

    logic [31:0]      grf_reg [32];
    logic [CNT_W-1:0] cnt_reg;

    assign op          = W_Instr[31:26];
    assign funct       = W_Instr[5:0];
    assign rt          = W_Instr[20:16];
    assign rd          = W_Instr[15:11];
    assign link_addr   = W_pc + LINK_OFFSET;
    assign unused_bits = ^{W_Instr[25:21], W_Instr[10:6]};

    // Little-endian byte lanes of the loaded word
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = W_RD[8*gi +: 8];
    end

    assign byte_sel = lane[W_C[1:0]];
    assign half_sel = W_C[1] ? W_RD[31:16] : W_RD[15:0];

    always_comb begin
        dec_write = 1'b0;
        dec_a3    = 5'd0;
        dec_wd    = 32'd0;
        case (op)
            OP_RTYPE: begin
                if (funct == FN_ADDU || funct == FN_SUBU) begin
                    dec_write = 1'b1;
                    dec_a3    = rd;
                    dec_wd    = W_C;
                end else if (funct == FN_JALR) begin
                    dec_write = 1'b1;
                    dec_a3    = rd;
                    dec_wd    = link_addr;
                end
            end
            OP_ORI: begin
                dec_write = 1'b1;
                dec_a3    = rt;
                dec_wd    = W_C;
            end
            OP_LUI: begin
                dec_write = 1'b1;
                dec_a3    = rt;
                dec_wd    = W_EXTout;
            end
            OP_LW: begin
                dec_write = 1'b1;
                dec_a3    = rt;
                dec_wd    = W_RD;
            end
            OP_LB, OP_LBU: begin
                dec_write = 1'b1;
                dec_a3    = rt;
                dec_wd    = {{24{(op == OP_LB) & byte_sel[7]}}, byte_sel};
            end
            OP_LH, OP_LHU: begin
                dec_write = 1'b1;
                dec_a3    = rt;
                dec_wd    = {{16{(op == OP_LH) & half_sel[15]}}, half_sel};
            end
            OP_JAL: begin
                dec_write = 1'b1;
                dec_a3    = 5'd31;
                dec_wd    = link_addr;
            end
            default: begin
                dec_write = 1'b0;
            end
        endcase
    end

    // $0 destinations are suppressed but the computed data stays visible
    assign W_WE = dec_write && (dec_a3 != 5'd0);
    assign W_A3 = W_WE ? dec_a3 : 5'd0;
    assign W_WD = dec_wd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                grf_reg[i] <= 32'd0;
            end
        end else if (W_WE) begin
            grf_reg[W_A3] <= W_WD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (W_Instr != 32'd0) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign retire_cnt = cnt_reg;

    always_comb begin
        if (W_WE && (W_A3 == A1) && (A1 != 5'd0)) begin
            RD1 = W_WD;
        end else if (A1 == 5'd0) begin
            RD1 = 32'd0;
        end else begin
            RD1 = grf_reg[A1];
        end
    end

    always_comb begin
        if (W_WE && (W_A3 == A2) && (A2 != 5'd0)) begin
            RD2 = W_WD;
        end else if (A2 == 5'd0) begin
            RD2 = 32'd0;
        end else begin
            RD2 = grf_reg[A2];
        end
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back (W) stage of the five-stage MIPS pipeline.
- Consumes the fields latched by the MEM/WB pipeline register: instruction, PC, ALU result, memory read data and extended immediate.
- Decodes the instruction locally, builds the register write (including sub-word load extraction and link address), and owns the 32x32 general register file (GRF).
- Provides two bypassed read ports to the D stage and a retired-instruction counter.

Parameters:
- LINK_OFFSET, 8, value added to W_pc to form the link address for jal/jalr.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- W_Instr  input  32  instruction in W; 0 = nop/bubble.
- W_pc  input  32  PC of the W instruction.
- W_C  input  32  ALU result; also the memory address for loads.
- W_RD  input  32  raw word read from data memory.
- W_EXTout  input  32  extended immediate (lui result).
- A1  input  5  read port 1 address.
- A2  input  5  read port 2 address.
- RD1  output  32  read port 1 data.
- RD2  output  32  read port 2 data.
- W_WE  output  1  register write enable this cycle; also used for D-stage forwarding.
- W_A3  output  5  destination register; 0 when W_WE=0.
- W_WD  output  32  write data.
- retire_cnt  output  CNT_W  count of non-nop instructions retired.

Behaviour:
- Decode uses op = W_Instr[31:26], funct = W_Instr[5:0].
- Write cases (all combinational):
  - addu (op 0, funct 0x21) / subu (op 0, funct 0x23): A3 = rd, WD = W_C.
  - ori (0x0D): A3 = rt, WD = W_C.
  - lui (0x0F): A3 = rt, WD = W_EXTout.
  - lw (0x23): A3 = rt, WD = W_RD.
  - lb (0x20) / lbu (0x24): byte k = W_C[1:0], little-endian, taken from W_RD[8k+7:8k]; sign-extended for lb, zero-extended for lbu. A3 = rt.
  - lh (0x21) / lhu (0x25): half selected by W_C[1] (0 = [15:0], 1 = [31:16]); sign- or zero-extended. A3 = rt. W_C[0] is ignored.
  - jal (0x03): A3 = 31, WD = W_pc + LINK_OFFSET, mod 2^32.
  - jalr (op 0, funct 0x09): A3 = rd, WD = W_pc + LINK_OFFSET, mod 2^32.
  - All other encodings (sw, beq, jr, nop, unknown): W_WE = 0, W_A3 = 0, W_WD = 0.
- Destination $0: any decoded write with A3 = 0 forces W_WE = 0 and W_A3 = 0. W_WD still shows the computed value.
- GRF:
  - On posedge clk with reset high and W_WE = 1, GRF[W_A3] <= W_WD.
  - GRF[0] always reads 0.
- Read ports are combinational.
  - If W_WE = 1 and W_A3 = A1 (A1 != 0), RD1 = W_WD (write-first bypass). Same rule for RD2 with A2.
  - Otherwise RDx = GRF[Ax].
  - A1 = A2 is legal; both ports return identical data.
- retire_cnt: on posedge, increments by 1 when W_Instr != 0, including non-writing instructions such as sw and beq. Wraps from 2^CNT_W - 1 to 0.
- Reset (reset = 0):
  - Immediately, without waiting for a clock edge, GRF[1..31] = 0 and retire_cnt = 0. RD1/RD2 therefore read 0 unless bypassing.
  - A write whose clock edge coincides with reset asserted is discarded.
  - Writes resume on the first posedge after reset returns high.
- W_WE/W_A3/W_WD have no reset value of their own: they are pure functions of the inputs. The upstream register zeroes W_Instr on reset, which yields WE = 0, A3 = 0, WD = 0.
- Latency: write data is visible at RDx combinationally in the same cycle (via bypass) and from the GRF on every cycle after the edge.

Test Plan:
- Reset then addu $3,$1,$2 (0x00221821), W_C = 0x00000007 -> W_WE = 1, W_A3 = 3; A1 = 3 gives RD1 = 7 before the edge (bypass) and after it; retire_cnt = 1.
- ori $0,$0,1 (0x34000001), W_C = 1 -> W_WE = 0, W_A3 = 0; A1 = 0 reads 0; retire_cnt still increments.
- W_RD = 0x8899AABB, W_C = 0x00000002:
  - lb $4 (0x80040000) -> $4 = 0xFFFFFF99.
  - lbu $4 (0x90040000) -> $4 = 0x00000099.
  - lh $4 (0x84040000) -> $4 = 0xFFFF8899.
  - lhu $4 (0x94040000) -> $4 = 0x00008899.
- jal (0x0C000000) with W_pc = 0x00003000 -> $31 = 0x00003008. jr $31 (0x03E00008) -> W_WE = 0.
- Load $5 = 0x12345678, then pull reset low mid-cycle -> RD1 (A1 = 5) drops to 0 before the next clock edge and retire_cnt = 0. A write presented during reset is not stored.
- Preload retire_cnt path to 0xFFFFFFFF (force), retire one non-nop -> retire_cnt = 0. A stream of zero instructions leaves it unchanged.
